// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   WORD_W           instruction / address width
//   NOP_INSTR        word presented on the fetch output when nothing is valid
//   RESET_PC_DEFAULT default reset PC for the fetch queue
//   STAT_W           width of the optional fetch statistics counters
//   fetch_state_e    fetch FSM encoding (IDLE / WAIT / DISCARD)
//   fetch_entry_t    prefetch FIFO entry {instruction, pc_plus4}
//   sat_add          saturating add used by the statistics counters
package pipeline_pkg;

  localparam int unsigned       WORD_W           = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0;
  localparam int unsigned       STAT_W           = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W:0]   inc);
    logic [STAT_W+1:0] sum;
    sum = {2'b00, a} + {1'b0, inc};
    return (sum > {2'b00, {STAT_W{1'b1}}}) ? '1 : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Bus bundle for instruction_fetch_queue.
//   redirect_valid/redirect_pc  branch redirect from MEM
//   out_ready/out_valid/instruction/pc_plus4  IF/ID handshake
//   imem_req/imem_addr/imem_ack/imem_rdata    instruction memory req/ack
//   fetch_count/discard_count   optional statistics
// Modports: slave = fetch queue side, master = environment side.
interface instruction_fetch_queue_if;
  import pipeline_pkg::*;

  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              out_ready;
  logic              out_valid;
  logic [WORD_W-1:0] instruction;
  logic [WORD_W-1:0] pc_plus4;
  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;
  logic [STAT_W-1:0] fetch_count;
  logic [STAT_W-1:0] discard_count;

  modport slave (
    input  redirect_valid, redirect_pc, out_ready, imem_ack, imem_rdata,
    output out_valid, instruction, pc_plus4, imem_req, imem_addr,
           fetch_count, discard_count
  );

  modport master (
    output redirect_valid, redirect_pc, out_ready, imem_ack, imem_rdata,
    input  out_valid, instruction, pc_plus4, imem_req, imem_addr,
           fetch_count, discard_count
  );

endinterface

// File: rtl/instruction_fetch_queue_fifo.sv
// fetch_fifo: show-ahead FIFO for the prefetch queue.
//   clk, rst_n   clock, async active-low reset
//   push_i/data_i  write one entry
//   pop_i          remove head entry
//   flush_i        empty the FIFO (wins over push/pop)
//   head_o         current head entry (valid when !empty_o)
//   count_o/full_o/empty_o  occupancy
// DEPTH must be a power of 2 so pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Push into a full FIFO is only accepted alongside a pop.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch stage feeding IF/ID.
// Owns the PC, keeps at most one instruction-memory read outstanding,
// buffers returned words with PC+4 in a prefetch FIFO and handles
// branch redirects (flush + drop of any in-flight word).
//   clk, rst_n  clock, async active-low reset
//   bus         instruction_fetch_queue_if.slave (redirect, IF/ID, imem, stats)
// Parameters: DEPTH (power of 2, 2..16), RESET_PC (word aligned).
// Optional build macro FETCH_STATS_EN enables saturating fetch/discard
// counters; otherwise both counter outputs are tied to zero.
module instruction_fetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_queue_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0] pc_inc;
  logic              push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, count_after;
  fetch_entry_t      push_entry, head_entry;

  assign pc_inc      = fetch_pc_q + 32'd4;
  assign pop         = !fifo_empty && bus.out_ready && !bus.redirect_valid;
  assign push        = (state_q == WAIT) && bus.imem_ack && !bus.redirect_valid;
  assign push_entry  = '{instr: bus.imem_rdata, pc_plus4: pc_inc};
  assign count_after = fifo_count + CW'(push) - CW'(pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // Reissue from WAIT only if the slot for the next word is still free after
  // this cycle's push/pop, so an outstanding ack always has room.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_addr_d = imem_addr_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.redirect_valid && !fifo_full) begin
          state_d     = WAIT;
          imem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          state_d = bus.imem_ack ? IDLE : DISCARD;
        end else if (bus.imem_ack) begin
          fetch_pc_d = pc_inc;
          if (count_after < CW'(DEPTH)) imem_addr_d = pc_inc;
          else                          state_d     = IDLE;
        end
      end
      DISCARD: begin
        if (bus.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc & ~32'h3;
  end

  assign bus.out_valid   = !fifo_empty;
  assign bus.instruction = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign bus.pc_plus4    = fifo_empty ? '0 : head_entry.pc_plus4;
  assign bus.imem_req    = (state_q != IDLE);
  assign bus.imem_addr   = imem_addr_q;

`ifdef FETCH_STATS_EN
  logic [STAT_W-1:0] fetch_cnt_q, discard_cnt_q;
  logic [STAT_W:0]   discard_inc;
  logic              drop_ack;

  // A redirect drops every buffered entry plus any ack returning for the
  // abandoned request.
  assign drop_ack = bus.imem_ack &&
                    ((state_q == DISCARD) || ((state_q == WAIT) && bus.redirect_valid));
  assign discard_inc = (bus.redirect_valid ? {{(STAT_W+1-CW){1'b0}}, fifo_count} : '0)
                     + {{STAT_W{1'b0}}, drop_ack};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      fetch_cnt_q   <= sat_add(fetch_cnt_q, {{STAT_W{1'b0}}, pop});
      discard_cnt_q <= sat_add(discard_cnt_q, discard_inc);
    end
  end

  assign bus.fetch_count   = fetch_cnt_q;
  assign bus.discard_count = discard_cnt_q;
`else
  assign bus.fetch_count   = '0;
  assign bus.discard_count = '0;
`endif

endmodule
